// File: rtl/inv_chain_delay_meter_if.sv
// Observation/control bundle for the inverter-chain delay meter.
// The slave side (the block) takes the enable and drives every probe.
interface inv_chain_delay_meter_if #(
    parameter int VW    = 12,
    parameter int CNT_W = 16
);
    logic             en;
    logic             in_bit;
    logic [VW-1:0]    in_v;
    logic [VW-1:0]    a_v;
    logic [VW-1:0]    b_v;
    logic [VW-1:0]    c_v;
    logic [VW-1:0]    d_v;
    logic [CNT_W-1:0] delay;
    logic             delay_valid;

    modport master (
        output en,
        input  in_bit, in_v, a_v, b_v, c_v, d_v, delay, delay_valid
    );

    modport slave (
        input  en,
        output in_bit, in_v, a_v, b_v, c_v, d_v, delay, delay_valid
    );
endinterface

// File: rtl/inv_chain_delay_meter.sv
// Cycle-based 4-stage RC inverter chain with an internal square-wave
// source and a meter timing stage-0 to stage-1 threshold crossings.

// One inverter stage: first-order slew toward the rail opposite its driver.
module inv_stage #(
    parameter int            VW    = 12,
    parameter int            K     = 3,
    parameter logic [VW-1:0] RST_V = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic [VW-1:0] i_drv,
    output logic [VW-1:0] o_v,
    output logic          o_cross
);
    localparam logic [VW-1:0]        VMAX     = {VW{1'b1}};
    localparam logic signed [VW:0]   SNAP_LIM = (VW+1)'(1 << K);

    logic [VW-1:0]      r_v;
    logic [VW-1:0]      w_target;
    logic [VW-1:0]      w_next;
    logic signed [VW:0] w_diff;
    logic signed [VW:0] w_abs;
    logic signed [VW:0] w_step;
    logic signed [VW:0] w_sum;

    // Target rail from driver MSB (driver >= half scale pulls low), then
    // either snap when close or move by the floor-shifted difference.
    always_comb begin
        w_target = i_drv[VW-1] ? '0 : VMAX;
        w_diff   = $signed({1'b0, w_target}) - $signed({1'b0, r_v});
        w_abs    = w_diff[VW] ? -w_diff : w_diff;
        w_step   = w_diff >>> K;
        w_sum    = $signed({1'b0, r_v}) + w_step;
        w_next   = (w_abs < SNAP_LIM) ? w_target : VW'(w_sum);
    end

    // Stage voltage register, frozen while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_v <= RST_V;
        else if (i_en) r_v <= w_next;
    end

    assign o_v     = r_v;
    // Side of the threshold flips on this enabled edge.
    assign o_cross = i_en & (w_next[VW-1] ^ r_v[VW-1]);
endmodule

module inv_chain_delay_meter #(
    parameter int HALF_PERIOD    = 50,
    parameter int VW             = 12,
    parameter int TAU_SHIFT      = 3,
    parameter int TAU_SHIFT_LAST = 1,
    parameter int CNT_W          = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    inv_chain_delay_meter_if.slave   bus
);
    localparam int               HP_W     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [VW-1:0]    VMAX     = {VW{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam int               N_STAGES = 4;

    typedef enum logic {S_IDLE, S_ARMED} state_t;

    logic [HP_W-1:0]               r_hp_cnt;
    logic                          r_in_bit;
    logic [VW-1:0]                 r_in_v;
    logic [N_STAGES:0][VW-1:0]     w_node;
    logic [N_STAGES-1:0]           w_cross;
    logic                          w_unused_cross;

    state_t                        r_state, w_state_nxt;
    logic [CNT_W-1:0]              r_count, w_count_nxt, w_count_inc;
    logic [CNT_W-1:0]              r_delay, w_delay_nxt;
    logic                          r_valid, w_report;

    // Square-wave source: toggle every HALF_PERIOD enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hp_cnt <= '0;
            r_in_bit <= 1'b0;
            r_in_v   <= '0;
        end else if (bus.en) begin
            if (r_hp_cnt == HP_W'(HALF_PERIOD - 1)) begin
                r_hp_cnt <= '0;
                r_in_bit <= ~r_in_bit;
                r_in_v   <= r_in_bit ? '0 : VMAX;
            end else begin
                r_hp_cnt <= r_hp_cnt + 1'b1;
            end
        end
    end

    assign w_node[0] = r_in_v;

    // Even stages rest high and odd stages low for a low input; the last
    // stage is unloaded and therefore slews faster.
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
        inv_stage #(
            .VW    (VW),
            .K     ((gi == N_STAGES - 1) ? TAU_SHIFT_LAST : TAU_SHIFT),
            .RST_V ((gi % 2 == 0) ? VMAX : '0)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_en    (bus.en),
            .i_drv   (w_node[gi]),
            .o_v     (w_node[gi+1]),
            .o_cross (w_cross[gi])
        );
    end

    // Only stages 0 and 1 are timed.
    assign w_unused_cross = ^w_cross[N_STAGES-1:2];

    // Meter next-state: arm on a-crossing, report count+1 on b-crossing.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_delay_nxt = r_delay;
        w_report    = 1'b0;
        w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;
        if (bus.en) begin
            case (r_state)
                S_IDLE: begin
                    if (w_cross[0] && w_cross[1]) begin
                        w_delay_nxt = '0;
                        w_report    = 1'b1;
                    end else if (w_cross[0]) begin
                        w_state_nxt = S_ARMED;
                        w_count_nxt = '0;
                    end
                end
                S_ARMED: begin
                    w_count_nxt = w_count_inc;
                    if (w_cross[1]) begin
                        w_delay_nxt = w_count_inc;
                        w_report    = 1'b1;
                        if (w_cross[0]) w_count_nxt = '0;
                        else            w_state_nxt = S_IDLE;
                    end else if (w_cross[0]) begin
                        w_count_nxt = '0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Meter registers; the valid pulse clears on every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_delay <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_report;
            if (bus.en) begin
                r_state <= w_state_nxt;
                r_count <= w_count_nxt;
                r_delay <= w_delay_nxt;
            end
        end
    end

    assign bus.in_bit      = r_in_bit;
    assign bus.in_v        = r_in_v;
    assign bus.a_v         = w_node[1];
    assign bus.b_v         = w_node[2];
    assign bus.c_v         = w_node[3];
    assign bus.d_v         = w_node[4];
    assign bus.delay       = r_delay;
    assign bus.delay_valid = r_valid;
endmodule

// File: tb/tb_inv_chain_delay_meter.sv
// Bench for inv_chain_delay_meter: two instances (default slew and
// TAU_SHIFT=2) against an arithmetic reference model, plus directed checks.
module tb_inv_chain_delay_meter;
    localparam int HP      = 50;
    localparam int VMAX    = 4095;
    localparam int THR     = 2048;
    localparam int CNT_MAX = 65535;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_r = 1'b1;
    always #5 clk = ~clk;

    inv_chain_delay_meter_if if0 ();
    inv_chain_delay_meter_if if1 ();
    assign if0.en = en_r;
    assign if1.en = en_r;

    inv_chain_delay_meter dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    inv_chain_delay_meter #(.TAU_SHIFT(2)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_n;                 // enabled edges since reset
    int m_v[2][5];           // [inst][0]=in_v, [1..4]=stages
    int m_in[2];
    int m_armed[2], m_arm[2], m_delay[2], m_valid[2];

    function automatic int kof(input int inst, input int s);
        if (s == 4) return 1;
        return (inst == 0) ? 3 : 2;
    endfunction

    function automatic int fdiv(input int d, input int p);
        if (d >= 0) return d / p;
        return -((-d + p - 1) / p);
    endfunction

    function automatic int stage_next(input int v, input int drv, input int k);
        int p, tgt, d;
        p   = 1 << k;
        tgt = (drv >= THR) ? 0 : VMAX;
        d   = tgt - v;
        if (d > -p && d < p) return tgt;
        return v + fdiv(d, p);
    endfunction

    task automatic model_reset();
        m_n = 0;
        for (int i = 0; i < 2; i++) begin
            m_v[i] = '{0, VMAX, 0, VMAX, 0};
            m_in[i] = 0; m_armed[i] = 0; m_arm[i] = 0;
            m_delay[i] = 0; m_valid[i] = 0;
        end
    endtask

    task automatic model_step();
        int nv[5];
        bit ca, cb;
        m_n++;
        for (int i = 0; i < 2; i++) begin
            m_in[i] = (m_n / HP) % 2;
            nv[0] = m_in[i] ? VMAX : 0;
            for (int s = 1; s < 5; s++) nv[s] = stage_next(m_v[i][s], m_v[i][s-1], kof(i, s));
            ca = (m_v[i][1] >= THR) != (nv[1] >= THR);
            cb = (m_v[i][2] >= THR) != (nv[2] >= THR);
            m_v[i] = nv;
            m_valid[i] = 0;
            if (cb && m_armed[i]) begin
                m_delay[i] = (m_n - m_arm[i] > CNT_MAX) ? CNT_MAX : m_n - m_arm[i];
                m_valid[i] = 1;
                m_armed[i] = ca;
                m_arm[i]   = m_n;
            end else if (cb && ca) begin
                m_delay[i] = 0;
                m_valid[i] = 1;
            end else if (ca) begin
                m_armed[i] = 1;
                m_arm[i]   = m_n;
            end
        end
    endtask

    task automatic compare_all();
        int act[2][8];
        act[0] = '{int'(if0.in_bit), int'(if0.in_v), int'(if0.a_v), int'(if0.b_v),
                   int'(if0.c_v), int'(if0.d_v), int'(if0.delay), int'(if0.delay_valid)};
        act[1] = '{int'(if1.in_bit), int'(if1.in_v), int'(if1.a_v), int'(if1.b_v),
                   int'(if1.c_v), int'(if1.d_v), int'(if1.delay), int'(if1.delay_valid)};
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.in_bit", i), act[i][0], m_in[i]);
            chk($sformatf("u%0d.in_v", i),   act[i][1], m_v[i][0]);
            chk($sformatf("u%0d.a_v", i),    act[i][2], m_v[i][1]);
            chk($sformatf("u%0d.b_v", i),    act[i][3], m_v[i][2]);
            chk($sformatf("u%0d.c_v", i),    act[i][4], m_v[i][3]);
            chk($sformatf("u%0d.d_v", i),    act[i][5], m_v[i][4]);
            chk($sformatf("u%0d.delay", i),  act[i][6], m_delay[i]);
            chk($sformatf("u%0d.valid", i),  act[i][7], m_valid[i]);
        end
    endtask

    task automatic drive(input bit e, input bit r);
        @(negedge clk);
        en_r = e;
        rst  = r;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst)       model_reset();
        else if (en_r) model_step();
        else           m_valid = '{0, 0};
        #1;
        compare_all();
    endtask

    task automatic chk_reset_consts(input string tag);
        chk({tag, ".a_v"},   int'(if0.a_v), 4095);
        chk({tag, ".b_v"},   int'(if0.b_v), 0);
        chk({tag, ".c_v"},   int'(if0.c_v), 4095);
        chk({tag, ".d_v"},   int'(if0.d_v), 0);
        chk({tag, ".in_v"},  int'(if0.in_v), 0);
        chk({tag, ".delay"}, int'(if0.delay), 0);
        chk({tag, ".valid"}, int'(if0.delay_valid), 0);
    endtask

    int a_seq[6]  = '{3583, 3135, 2743, 2400, 2100, 1837};
    int b_seq[6]  = '{511, 959, 1351, 1694, 1994, 2256};
    int b1_seq[3] = '{1023, 1791, 2367};

    initial begin
        int ecnt, pulses0, pulses1, rise_at, bound;
        model_reset();
        // reset held with en high: chain must sit at its low-input state
        for (int c = 0; c < 4; c++) begin drive(1, 1); tick(); end
        chk_reset_consts("rst");

        // free run, two full stimulus periods
        ecnt = 0; pulses0 = 0; pulses1 = 0; rise_at = -1;
        for (int c = 0; c < 200; c++) begin
            drive(1, 0); tick(); ecnt++;
            if (rise_at < 0 && if0.in_bit) begin
                rise_at = ecnt;
                chk("first_rise_edge", rise_at, 50);
                chk("first_rise_in_v", int'(if0.in_v), 4095);
            end
            if (ecnt >= 51 && ecnt <= 56) chk("a_fall_seq", int'(if0.a_v), a_seq[ecnt-51]);
            if (ecnt >= 57 && ecnt <= 62) chk("b_rise_seq", int'(if0.b_v), b_seq[ecnt-57]);
            if (ecnt >= 54 && ecnt <= 56) chk("b_rise_seq_k2", int'(if1.b_v), b1_seq[ecnt-54]);
            if (if0.delay_valid) begin pulses0++; chk("delay_k3", int'(if0.delay), 6); end
            if (if1.delay_valid) begin pulses1++; chk("delay_k2", int'(if1.delay), 3); end
        end
        chk("pulses_k3", pulses0, 3);
        chk("pulses_k2", pulses1, 3);

        // freeze for 10 cycles while armed
        bound = 0;
        while (!m_armed[0] && bound < 80) begin drive(1, 0); tick(); bound++; end
        chk("armed_before_freeze", m_armed[0], 1);
        for (int c = 0; c < 10; c++) begin drive(0, 0); tick(); end
        bound = 0;
        while (!if0.delay_valid && bound < 80) begin drive(1, 0); tick(); bound++; end
        chk("freeze_valid_seen", int'(if0.delay_valid), 1);
        chk("freeze_delay", int'(if0.delay), 6);

        // reset while armed: no pulse, immediate return to reset values
        bound = 0;
        while (!m_armed[0] && bound < 120) begin drive(1, 0); tick(); bound++; end
        chk("armed_before_rst", m_armed[0], 1);
        drive(1, 1);
        #1;
        model_reset();
        chk_reset_consts("midrst");
        tick();
        drive(1, 1); tick();
        chk("midrst_in_bit", int'(if0.in_bit), 0);

        // randomized enable and occasional reset
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 99) < 85, $urandom_range(0, 399) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule
